// File: rtl/core_pkg.sv
// Shared definitions for the MEM stage load/store unit: funct3 codes, FSM encoding, size helpers.
package core_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_e;

  // funct3[1:0] encodes log2 of the access size in bytes
  function automatic logic [7:0] size_mask(input logic [1:0] sz);
    case (sz)
      2'b00:   return 8'h01;
      2'b01:   return 8'h03;
      2'b10:   return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/mem_stage_lsu_if.sv
// Data-memory request/acknowledge bus; the LSU is the master, the memory the slave.
interface mem_stage_lsu_if #(
  parameter int XLEN = 64
) ();
  logic              req;
  logic              we;
  logic [XLEN-1:0]   addr;
  logic [XLEN/8-1:0] be;
  logic [XLEN-1:0]   wdata;
  logic              ack;
  logic [XLEN-1:0]   rdata;

  modport master (output req, we, addr, be, wdata, input ack, rdata);
  modport slave  (input req, we, addr, be, wdata, output ack, rdata);
endinterface

// File: rtl/lsu_align.sv
// Combinational lane alignment: byte enables, store-data shift, load extract and sign/zero extend.
module lsu_align
  import core_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]                  funct3,
  input  logic [$clog2(XLEN/8)-1:0]   offset,
  input  logic [XLEN-1:0]             sr2,
  input  logic [XLEN-1:0]             rdata,
  output logic [XLEN/8-1:0]           be,
  output logic [XLEN-1:0]             wdata,
  output logic [XLEN-1:0]             ld_data
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);

  logic [OFF_W+2:0] bit_off;
  logic [XLEN-1:0]  sh;

  assign bit_off = {offset, 3'b000};
  assign be      = NB'(size_mask(funct3[1:0])) << offset;
  assign wdata   = sr2 << bit_off;
  assign sh      = rdata >> bit_off;

  always_comb begin
    ld_data = sh;
    case (funct3)
      F3_B:    ld_data = XLEN'($signed(sh[7:0]));
      F3_H:    ld_data = XLEN'($signed(sh[15:0]));
      F3_W:    ld_data = XLEN'($signed(sh[31:0]));
      F3_BU:   ld_data = XLEN'(sh[7:0]);
      F3_HU:   ld_data = XLEN'(sh[15:0]);
      F3_WU:   ld_data = XLEN'(sh[31:0]);
      default: ld_data = sh;
    endcase
  end
endmodule

// File: rtl/mem_stage_lsu.sv
// MEM->WB stage with load/store unit; memory ops take >=3 cycles (IDLE, REQ, DONE) with MEM_STALL held meanwhile.
// WB_STALL freezes all WB_* outputs; faults skip the bus request and retire straight from DONE.
module mem_stage_lsu
  import core_pkg::*;
#(
  parameter int          XLEN     = 64,
  parameter int          REGID_W  = 5,
  parameter logic [63:0] MEM_BASE = 64'h0000_0000_8000_0000,
  parameter logic [63:0] MEM_SIZE = 64'h0000_0000_0001_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               MEM_V,
  input  logic               MEM_LD,
  input  logic               MEM_ST,
  input  logic [2:0]         MEM_FUNCT3,
  input  logic [XLEN-1:0]    MEM_ALU_RESULT,
  input  logic [XLEN-1:0]    MEM_SR2,
  input  logic [XLEN-1:0]    MEM_NPC,
  input  logic [XLEN-1:0]    MEM_CSRFD,
  input  logic               MEM_RFD,
  input  logic [REGID_W-1:0] MEM_DRID,
  input  logic               MEM_ECALL,
  input  logic               WB_STALL,
  output logic               MEM_STALL,
  mem_stage_lsu_if.master    dmem,
  output logic               WB_V,
  output logic               WB_RFD,
  output logic               WB_ECALL,
  output logic [XLEN-1:0]    WB_NPC,
  output logic [XLEN-1:0]    WB_CSRFD,
  output logic [XLEN-1:0]    WB_ALU_RESULT,
  output logic [XLEN-1:0]    WB_MEM_RESULT,
  output logic [REGID_W-1:0] WB_DRID,
  output logic               WB_LAM,
  output logic               WB_LAF,
  output logic               WB_SAM,
  output logic               WB_SAF
);
  localparam int NB    = XLEN / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [XLEN:0] BASE_X  = {1'b0, MEM_BASE[XLEN-1:0]};
  localparam logic [XLEN:0] LIMIT_X = BASE_X + {1'b0, MEM_SIZE[XLEN-1:0]};

  lsu_state_e state, state_nx;

  logic               a_ld, a_rfd, a_ecall, am_q, af_q;
  logic [2:0]         a_f3;
  logic [XLEN-1:0]    a_addr, a_sr2, a_npc, a_csrfd, rdata_q, ld_data;
  logic [REGID_W-1:0] a_drid;
  logic [CNT_W-1:0]   cnt;
  logic [NB-1:0]      be_w;
  logic [XLEN-1:0]    wdata_w;
  logic               is_mem, misal, oor, timeout, exc;
  logic [XLEN:0]      addr_x, end_x;

  assign is_mem  = MEM_V && (MEM_LD || MEM_ST);
  assign addr_x  = {1'b0, MEM_ALU_RESULT};
  assign end_x   = addr_x + (XLEN+1)'(size_bytes(MEM_FUNCT3[1:0]));
  assign oor     = (addr_x < BASE_X) || (end_x > LIMIT_X);
  assign timeout = (state == ST_REQ) && !dmem.ack && (cnt == CNT_W'(TIMEOUT - 1));
  assign exc     = am_q || af_q;

  // funct3=111 has no legal size, so it falls into the misaligned bucket with D on RV32
  always_comb begin
    misal = 1'b0;
    case (MEM_FUNCT3[1:0])
      2'b00: misal = 1'b0;
      2'b01: misal = MEM_ALU_RESULT[0];
      2'b10: misal = |MEM_ALU_RESULT[1:0];
      2'b11: misal = (XLEN == 32) || MEM_FUNCT3[2] || (|MEM_ALU_RESULT[2:0]);
    endcase
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3  (a_f3),
    .offset  (a_addr[OFF_W-1:0]),
    .sr2     (a_sr2),
    .rdata   (rdata_q),
    .be      (be_w),
    .wdata   (wdata_w),
    .ld_data (ld_data)
  );

  assign dmem.req   = (state == ST_REQ);
  assign dmem.we    = !a_ld;
  assign dmem.addr  = {a_addr[XLEN-1:OFF_W], OFF_W'(0)};
  assign dmem.be    = be_w;
  assign dmem.wdata = wdata_w;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    MEM_STALL = 1'b0;
    case (state)
      ST_IDLE: if (is_mem) begin
        MEM_STALL = 1'b1;
        state_nx  = (misal || oor) ? ST_DONE : ST_REQ;
      end
      ST_REQ: begin
        MEM_STALL = 1'b1;
        if (dmem.ack || timeout) state_nx = ST_DONE;
      end
      ST_DONE: begin
        MEM_STALL = WB_STALL;
        if (!WB_STALL) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      {a_ld, a_rfd, a_ecall, am_q, af_q} <= '0;
      {a_f3, a_addr, a_sr2, a_npc, a_csrfd, rdata_q, a_drid, cnt} <= '0;
      {WB_V, WB_RFD, WB_ECALL, WB_LAM, WB_LAF, WB_SAM, WB_SAF} <= '0;
      {WB_NPC, WB_CSRFD, WB_ALU_RESULT, WB_MEM_RESULT, WB_DRID} <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (is_mem) begin
            a_ld    <= MEM_LD;
            a_f3    <= MEM_FUNCT3;
            a_addr  <= MEM_ALU_RESULT;
            a_sr2   <= MEM_SR2;
            a_npc   <= MEM_NPC;
            a_csrfd <= MEM_CSRFD;
            a_rfd   <= MEM_RFD;
            a_drid  <= MEM_DRID;
            a_ecall <= MEM_ECALL;
            am_q    <= misal;
            af_q    <= !misal && oor;
            cnt     <= '0;
            if (!WB_STALL) WB_V <= 1'b0;
          end else if (!WB_STALL) begin
            WB_V          <= MEM_V;
            WB_RFD        <= MEM_RFD;
            WB_ECALL      <= MEM_ECALL;
            WB_NPC        <= MEM_NPC;
            WB_CSRFD      <= MEM_CSRFD;
            WB_ALU_RESULT <= MEM_ALU_RESULT;
            WB_DRID       <= MEM_DRID;
            WB_MEM_RESULT <= '0;
            {WB_LAM, WB_LAF, WB_SAM, WB_SAF} <= '0;
          end
        end
        ST_REQ: begin
          cnt <= cnt + CNT_W'(1);
          if (dmem.ack) rdata_q <= dmem.rdata;
          if (timeout)  af_q    <= 1'b1;
          if (!WB_STALL) WB_V <= 1'b0;
        end
        ST_DONE: if (!WB_STALL) begin
          WB_V          <= 1'b1;
          WB_RFD        <= a_rfd && a_ld && !exc;
          WB_ECALL      <= a_ecall;
          WB_NPC        <= a_npc;
          WB_CSRFD      <= a_csrfd;
          WB_ALU_RESULT <= a_addr;
          WB_DRID       <= a_drid;
          WB_MEM_RESULT <= (a_ld && !exc) ? ld_data : '0;
          WB_LAM        <= a_ld && am_q;
          WB_LAF        <= a_ld && af_q;
          WB_SAM        <= !a_ld && am_q;
          WB_SAF        <= !a_ld && af_q;
          cnt           <= '0;
        end
        default: ;
      endcase
    end
  end
endmodule
